// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, issues one outstanding request at a time
// to a variable-latency instruction memory, and queues returned instructions with their
// addresses for the IF/ID stage.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   mem_req, mem_addr   registered one-cycle request pulse and held request address
//   mem_valid, mem_data memory response strobe and instruction word
//   out_valid           head entry available
//   out_instruction     head instruction (0 when empty)
//   out_pc              head address (0 when empty)
//   out_pc_plus1        head address + 1, wrapping (0 when empty)
//   consume             pipeline takes the head entry this cycle
//   redirect_en         restart fetch at redirect_pc, flushing the queue
//   redirect_pc         new fetch address
//   fetch_pc            next address to request
//   count               queue occupancy
module instr_prefetch_buffer #(
  parameter int unsigned ADDRESS_LEN     = 12,
  parameter int unsigned INSTRUCTION_LEN = 19,
  parameter int unsigned DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [ADDRESS_LEN-1:0]     mem_addr,
  input  logic                       mem_valid,
  input  logic [INSTRUCTION_LEN-1:0] mem_data,
  output logic                       out_valid,
  output logic [INSTRUCTION_LEN-1:0] out_instruction,
  output logic [ADDRESS_LEN-1:0]     out_pc,
  output logic [ADDRESS_LEN-1:0]     out_pc_plus1,
  input  logic                       consume,
  input  logic                       redirect_en,
  input  logic [ADDRESS_LEN-1:0]     redirect_pc,
  output logic [ADDRESS_LEN-1:0]     fetch_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e                     state_q;
  logic                       mem_req_q;
  logic [ADDRESS_LEN-1:0]     mem_addr_q;
  logic [ADDRESS_LEN-1:0]     fetch_pc_q;
  logic [CW-1:0]              count_q;
  logic [PW-1:0]              wr_ptr_q;
  logic [PW-1:0]              rd_ptr_q;

  logic [INSTRUCTION_LEN-1:0] instr_mem [DEPTH];
  logic [ADDRESS_LEN-1:0]     pc_mem    [DEPTH];

  logic push;
  logic pop;
  logic full;

  // A request is only issued while count < DEPTH and only one is ever outstanding, so the
  // slot for the response is implicitly reserved and push never needs a full check.
  assign push = (state_q == StWait) && mem_valid && !redirect_en;
  assign pop  = consume && (count_q != '0) && !redirect_en;
  assign full = (count_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      mem_req_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // mem_valid here is a protocol violation and is ignored.
          if (!redirect_en && !full) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (mem_valid) begin
            state_q <= StIdle;
          end else if (redirect_en) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          // The stale response retires the outstanding request even if another redirect
          // arrives in the same cycle; otherwise the FSM would wait forever.
          if (mem_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (redirect_en) begin
        fetch_pc_q <= redirect_pc;
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (push) begin
          fetch_pc_q <= fetch_pc_q + ADDRESS_LEN'(1);
          wr_ptr_q   <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Queue storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= mem_data;
      pc_mem[wr_ptr_q]    <= mem_addr_q;
    end
  end

  always_comb begin
    out_valid       = (count_q != '0);
    out_instruction = '0;
    out_pc          = '0;
    out_pc_plus1    = '0;
    if (out_valid) begin
      out_instruction = instr_mem[rd_ptr_q];
      out_pc          = pc_mem[rd_ptr_q];
      out_pc_plus1    = pc_mem[rd_ptr_q] + ADDRESS_LEN'(1);
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign fetch_pc = fetch_pc_q;
  assign count    = count_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a latency-programmable memory model that
// returns addr + 0x100 as the instruction word.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [18:0] mem_data = '0;
  logic        out_valid;
  logic [18:0] out_instruction;
  logic [11:0] out_pc;
  logic [11:0] out_pc_plus1;
  logic        consume = 1'b0;
  logic        redirect_en = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic [11:0] fetch_pc;
  logic [2:0]  count;

  int passes = 0;
  int total  = 0;
  int lat    = 1;
  int overlap = 0;

  instr_prefetch_buffer #(
    .ADDRESS_LEN(12),
    .INSTRUCTION_LEN(19),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_data(mem_data),
    .out_valid(out_valid),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .out_pc_plus1(out_pc_plus1),
    .consume(consume),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  // Memory model: a request seen in cycle E yields mem_valid during the cycle that ends at
  // edge E+lat.
  bit          pend = 1'b0;
  int          rem  = 0;
  logic [11:0] raddr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      pend      = 1'b0;
      mem_valid = 1'b0;
    end else begin
      mem_valid = 1'b0;
      if (mem_req) begin
        if (pend) overlap++;
        pend  = 1'b1;
        rem   = lat;
        raddr = mem_addr;
      end
      if (pend) begin
        rem--;
        if (rem == 0) begin
          mem_valid = 1'b1;
          mem_data  = 19'(raddr) + 19'h100;
          pend      = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    bit found;

    // ---- reset state and L=1 streaming with consume held high
    tick();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_fetch_pc", 32'(fetch_pc), 0);
    check("rst_out_pc_plus1", 32'(out_pc_plus1), 0);
    lat = 1;
    consume = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_req", 32'(mem_req), 1);
      check("stream_addr", 32'(mem_addr), 32'(i));
      check("stream_count0", 32'(count), 0);
      tick();
      check("stream_valid", 32'(out_valid), 1);
      check("stream_pc", 32'(out_pc), 32'(i));
      check("stream_pc1", 32'(out_pc_plus1), 32'(i + 1));
      check("stream_instr", 32'(out_instruction), 32'(i + 'h100));
      check("stream_count1", 32'(count), 1);
    end

    // ---- fill to DEPTH with consume low, then drain in order
    consume = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    check("full_count", 32'(count), 4);
    check("full_fetch_pc", 32'(fetch_pc), 4);
    check("full_head_pc", 32'(out_pc), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_req", 32'(mem_req), 0);
    end
    consume = 1'b1;
    tick();
    check("drain1_pc", 32'(out_pc), 1);
    check("drain1_count", 32'(count), 3);
    tick();
    check("drain2_pc", 32'(out_pc), 2);
    check("drain2_count", 32'(count), 2);
    check("resume_req", 32'(mem_req), 1);
    check("resume_addr", 32'(mem_addr), 4);
    tick();
    check("drain3_pc", 32'(out_pc), 3);
    check("drain3_count", 32'(count), 2);
    tick();
    check("drain4_pc", 32'(out_pc), 4);
    check("drain4_count", 32'(count), 1);

    // ---- L=3, redirect while waiting for the response to addr 2
    lat = 3;
    consume = 1'b1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (mem_req && mem_addr == 12'd2) found = 1'b1;
    end
    check("l3_req_addr2_seen", 32'(found), 1);
    tick();
    redirect_en = 1'b1;
    redirect_pc = 12'h0A5;
    tick();
    redirect_en = 1'b0;
    check("drop_count", 32'(count), 0);
    check("drop_fetch_pc", 32'(fetch_pc), 32'h0A5);
    check("drop_no_req", 32'(mem_req), 0);
    tick();
    check("drop_resp_not_queued", 32'(out_valid), 0);
    check("drop_still_no_req", 32'(mem_req), 0);
    tick();
    check("redir_req", 32'(mem_req), 1);
    check("redir_addr", 32'(mem_addr), 32'h0A5);
    tick();
    tick();
    tick();
    check("redir_head_valid", 32'(out_valid), 1);
    check("redir_head_pc", 32'(out_pc), 32'h0A5);
    check("redir_head_instr", 32'(out_instruction), 32'h1A5);

    // ---- redirect in the same cycle as mem_valid in WAIT
    lat = 1;
    consume = 1'b0;
    do_reset();
    tick();
    check("samecyc_req", 32'(mem_req), 1);
    redirect_en = 1'b1;
    redirect_pc = 12'h055;
    tick();
    redirect_en = 1'b0;
    check("samecyc_count", 32'(count), 0);
    check("samecyc_valid", 32'(out_valid), 0);
    check("samecyc_no_req", 32'(mem_req), 0);
    check("samecyc_fetch_pc", 32'(fetch_pc), 32'h055);
    tick();
    check("samecyc_next_req", 32'(mem_req), 1);
    check("samecyc_next_addr", 32'(mem_addr), 32'h055);
    tick();
    check("samecyc_head_pc", 32'(out_pc), 32'h055);
    for (int i = 0; i < 4; i++) tick();
    check("fill3_count", 32'(count), 3);
    check("fill3_head", 32'(out_pc), 32'h055);

    // ---- redirect with count=3 into a wrapping fetch sequence
    redirect_en = 1'b1;
    redirect_pc = 12'hFFE;
    tick();
    redirect_en = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_no_req", 32'(mem_req), 0);
    check("flush_fetch_pc", 32'(fetch_pc), 32'hFFE);
    consume = 1'b1;
    tick();
    check("wrap_addr_ffe", 32'(mem_addr), 32'hFFE);
    check("wrap_req_ffe", 32'(mem_req), 1);
    tick();
    check("wrap_pc_ffe", 32'(out_pc), 32'hFFE);
    check("wrap_pc1_ffe", 32'(out_pc_plus1), 32'hFFF);
    check("wrap_instr_ffe", 32'(out_instruction), 32'h10FE);
    tick();
    check("wrap_addr_fff", 32'(mem_addr), 32'hFFF);
    tick();
    check("wrap_pc_fff", 32'(out_pc), 32'hFFF);
    check("wrap_pc1_fff", 32'(out_pc_plus1), 32'h000);
    tick();
    check("wrap_addr_000", 32'(mem_addr), 32'h000);
    check("wrap_req_000", 32'(mem_req), 1);
    tick();
    check("wrap_pc_000", 32'(out_pc), 32'h000);
    check("wrap_pc1_000", 32'(out_pc_plus1), 32'h001);

    // ---- asynchronous reset mid-WAIT with two entries queued
    consume = 1'b0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("pre_areset_count", 32'(count), 2);
    check("pre_areset_req", 32'(mem_req), 1);
    check("pre_areset_addr", 32'(mem_addr), 2);
    #2;
    rst = 1'b0;
    #1;
    check("areset_req", 32'(mem_req), 0);
    check("areset_addr", 32'(mem_addr), 0);
    check("areset_valid", 32'(out_valid), 0);
    check("areset_instr", 32'(out_instruction), 0);
    check("areset_pc", 32'(out_pc), 0);
    check("areset_count", 32'(count), 0);
    check("areset_fetch_pc", 32'(fetch_pc), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post_areset_req", 32'(mem_req), 1);
    check("post_areset_addr", 32'(mem_addr), 0);

    check("single_outstanding", 32'(overlap), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
